// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sub
//  Description : Bit-serial WIDTH-bit adder/subtractor. It latches two operands
//                and a mode, then streams one bit pair per clock, LSB first,
//                through a single full-adder cell. The carry is held in a flop
//                between bits. Start/done handshake.
//                Optional zero flag: define SERIAL_ADD_SUB_ZERO_FLAG_EN to add
//                the o_zero output.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    // Only the most recent WIDTH-1 sum bits are kept; the current bit completes the word.
    logic [WIDTH-2:0]   r_sr;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic               r_res_carry;
    logic               r_overflow;

    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_sr_nxt;

`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    logic               r_nonzero;
    logic               r_zero;
`endif

    // Single full-adder cell fed by the LSBs of the operand shift registers
    always_comb begin
        w_s      = r_sa[0] ^ r_sb[0] ^ r_carry;
        w_cout   = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));
        w_sr_nxt = {w_s, r_sr};
        w_last   = (r_cnt == c_LAST);
    end

    // Next-state logic; an accept is possible from IDLE or from the DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, bit-serial datapath and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sa        <= '0;
            r_sb        <= '0;
            r_sr        <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_res_carry <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with the mode
            r_sa    <= i_a;
            r_sb    <= i_b ^ {WIDTH{i_mode}};
            r_carry <= i_mode;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
            r_sr    <= w_sr_nxt[WIDTH-1:1];
            r_carry <= w_cout;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_result    <= w_sr_nxt;
                r_res_carry <= w_cout;
                // Carry into the MSB differs from carry out of it on signed overflow
                r_overflow  <= r_carry ^ w_cout;
            end
        end
    end

`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    // Sticky nonzero tracker; the zero flag updates alongside the other results
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_nonzero <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_accept) begin
            r_nonzero <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_nonzero <= r_nonzero | w_s;
            if (w_last) begin
                r_zero <= ~(r_nonzero | w_s);
            end
        end
    end

    assign o_zero = r_zero;
`endif

    assign o_busy     = (r_state == S_RUN);
    assign o_done     = (r_state == S_DONE);
    assign o_result   = r_result;
    assign o_carry    = r_res_carry;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_sub
//  Description : Scoreboard testbench for serial_add_sub (WIDTH=8). Expected
//                results are queued at each accept; a monitor pops and
//                compares them whenever o_done is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_sub;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             z;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    logic             zero;
`endif

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_a        (a),
        .i_b        (b),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_carry    (carry),
        .o_overflow (overflow)
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
        ,
        .o_zero     (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each completed result against the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result",   32'(result),   32'(e.res));
                check("carry",    32'(carry),    32'(e.c));
                check("overflow", 32'(overflow), 32'(e.v));
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
                check("zero",     32'(zero),     32'(e.z));
`endif
            end
        end
    end

    // One isolated operation from IDLE, with latency and pulse-width checks
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tm, input logic [WIDTH-1:0] er,
                          input logic ec, input logic ev, input logic ez);
        int n;
        exp_t e;
        a     = ta;
        b     = tb;
        mode  = tm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = er; e.c = ec; e.v = ev; e.z = ez;
        q.push_back(e);
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 2 * WIDTH) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_latency", 32'(n), 32'(WIDTH));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    logic [WIDTH-1:0] bb_a   [4] = '{8'd10, 8'd3, 8'hFF, 8'h00};
    logic [WIDTH-1:0] bb_b   [4] = '{8'd20, 8'd3, 8'h01, 8'h80};
    logic             bb_m   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] bb_r   [4] = '{8'd30, 8'h00, 8'h00, 8'h80};
    logic             bb_c   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic             bb_v   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic             bb_z   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Stimulus
    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_result",   32'(result),   32'd0);
        check("rst_carry",    32'(carry),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
        check("rst_zero",     32'(zero),     32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1, 1'b0);
        run_op(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0);
        run_op(8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0, 1'b0);
        run_op(8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1, 1'b0);
        run_op(8'h55,  8'h55,  1'b1, 8'h00,  1'b1, 1'b0, 1'b1);
        run_op(8'd1,   8'd0,   1'b0, 8'd1,   1'b0, 1'b0, 1'b0);
        check("held_result", 32'(result), 32'd1);

        // Reset in the middle of an operation: nothing may complete
        a     = 8'd100;
        b     = 8'd27;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_done",     32'(done),     32'd0);
        check("midrst_result",   32'(result),   32'd0);
        check("midrst_carry",    32'(carry),    32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        repeat (2 * WIDTH) @(posedge clk);
        #1;
        run_op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0);

        // Back-to-back with i_start held; operands scrambled mid-run
        a     = bb_a[0];
        b     = bb_b[0];
        mode  = bb_m[0];
        start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            e.res = bb_r[j]; e.c = bb_c[j]; e.v = bb_v[j]; e.z = bb_z[j];
            q.push_back(e);
            repeat (3) @(posedge clk);
            #1;
            a    = ~bb_a[j];
            b    = bb_b[j] + 8'd37;
            mode = ~bb_m[j];
            repeat (5) @(posedge clk);
            #1;
            check("b2b_done", 32'(done), 32'd1);
            if (j < 3) begin
                a    = bb_a[j+1];
                b    = bb_b[j+1];
                mode = bb_m[j+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(busy), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
